// File: rtl/mycpu_div_unit_if.sv
// Handshake/bus bundle between EX (master) and the multi-cycle divider (slave).
interface mycpu_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic             cancel;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             stallreq;

  modport master (
    output start, signed_div, cancel, dividend, divisor,
    input  busy, ready, quotient, remainder, div_by_zero, stallreq
  );

  modport slave (
    input  start, signed_div, cancel, dividend, divisor,
    output busy, ready, quotient, remainder, div_by_zero, stallreq
  );
endinterface

// File: rtl/mycpu_div_unit.sv
// Restoring one-bit-per-cycle divider for MIPS DIV/DIVU: quotient -> LO, remainder -> HI.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module mycpu_div_unit #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  mycpu_div_unit_if.slave  div_if
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qs_q, qs_d;
  logic             rs_q, rs_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remd_q, remd_d;
  logic             dbz_out_q, dbz_out_d;

  logic             a_neg, b_neg, early, accept, finish, ge;
  logic [WIDTH-1:0] mag_a, mag_b, fix_q, fix_r, sub;
  logic [WIDTH:0]   shifted;

  assign a_neg  = div_if.signed_div & div_if.dividend[WIDTH-1];
  assign b_neg  = div_if.signed_div & div_if.divisor[WIDTH-1];
  assign mag_a  = a_neg ? -div_if.dividend : div_if.dividend;
  assign mag_b  = b_neg ? -div_if.divisor : div_if.divisor;
  assign accept = (state_q == IDLE) & div_if.start & ~div_if.cancel;
  assign finish = (state_q == DONE) & ~div_if.cancel;

`ifdef DIV_EARLY_OUT_EN
  assign early = (mag_b != '0) && (mag_a < mag_b);
`else
  assign early = 1'b0;
`endif

  // The low WIDTH bits of the difference are exact whenever the compare says it fits.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign ge      = shifted >= {1'b0, dvs_q};
  assign sub     = shifted[WIDTH-1:0] - dvs_q;
  assign fix_q   = qs_q ? -dvd_q : dvd_q;
  assign fix_r   = rs_q ? -rem_q : rem_q;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    qs_d      = qs_q;
    rs_d      = rs_q;
    dbz_d     = dbz_q;
    quot_d    = quot_q;
    remd_d    = remd_q;
    dbz_out_d = dbz_out_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Early-out preloads the remainder so DONE's sign fix-up yields q=0, r=dividend.
          rem_d   = early ? mag_a : '0;
          dvd_d   = early ? '0 : mag_a;
          dvs_d   = mag_b;
          cnt_d   = CNT_W'(WIDTH);
          qs_d    = a_neg ^ b_neg;
          rs_d    = a_neg;
          dbz_d   = (div_if.divisor == '0);
          state_d = early ? DONE : CALC;
        end
      end
      CALC: begin
        if (div_if.cancel) begin
          state_d = IDLE;
        end else begin
          rem_d = ge ? sub : shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], ge};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (finish) begin
          quot_d    = fix_q;
          remd_d    = fix_r;
          dbz_out_d = dbz_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      qs_q      <= 1'b0;
      rs_q      <= 1'b0;
      dbz_q     <= 1'b0;
      quot_q    <= '0;
      remd_q    <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      qs_q      <= qs_d;
      rs_q      <= rs_d;
      dbz_q     <= dbz_d;
      quot_q    <= quot_d;
      remd_q    <= remd_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  // Results are presented combinationally in the ready cycle so EX can retire without waiting.
  assign div_if.busy        = (state_q == CALC) || (state_q == DONE);
  assign div_if.stallreq    = accept || (state_q == CALC);
  assign div_if.ready       = finish;
  assign div_if.quotient    = finish ? fix_q : quot_q;
  assign div_if.remainder   = finish ? fix_r : remd_q;
  assign div_if.div_by_zero = finish ? dbz_q : dbz_out_q;
endmodule

// File: tb/tb_mycpu_div_unit.sv
// Self-checking bench for mycpu_div_unit: transaction-level reference model plus directed literals.
module tb_mycpu_div_unit;
  localparam int WIDTH = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = WIDTH + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  mycpu_div_unit_if #(.WIDTH(WIDTH)) div_if ();

  mycpu_div_unit #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (div_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: one in-flight operation with a deadline, plus last delivered results.
  bit          op_active = 1'b0;
  int          ready_cyc = 0;
  logic [31:0] pend_q = '0, pend_r = '0, held_q = '0, held_r = '0;
  logic        pend_dz = 1'b0, held_dz = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // MIPS semantics from plain arithmetic; divide-by-zero defined as q=all ones (then sign fix), r=dividend.
  function automatic void refDiv(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic dz, output int lat);
    longint sa, sb, ma, mb;
    dz = (b == 32'd0);
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (b == 32'd0) begin
      r = a;
      q = (sg && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
    lat = WIDTH + 1;
`ifdef DIV_EARLY_OUT_EN
    if (b != 32'd0 && ma < mb) lat = 1;
`else
    if (ma < 0 || mb < 0) lat = 0;
`endif
  endfunction

  // Single compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    logic        acc, exp_ready, exp_stall;
    logic [31:0] mq, mr;
    logic        mdz;
    int          lat;
    if (!rst) begin
      op_active = 1'b0;
      held_q = '0;
      held_r = '0;
      held_dz = 1'b0;
    end
    acc       = !op_active && div_if.start && !div_if.cancel;
    exp_ready = op_active && (cyc == ready_cyc) && !div_if.cancel;
    exp_stall = acc || (op_active && cyc < ready_cyc);
    checkOutput("busy", 32'(div_if.busy), 32'(op_active));
    checkOutput("ready", 32'(div_if.ready), 32'(exp_ready));
    checkOutput("stallreq", 32'(div_if.stallreq), 32'(exp_stall));
    checkOutput("quotient", div_if.quotient, exp_ready ? pend_q : held_q);
    checkOutput("remainder", div_if.remainder, exp_ready ? pend_r : held_r);
    checkOutput("div_by_zero", 32'(div_if.div_by_zero), 32'(exp_ready ? pend_dz : held_dz));
    if (rst) begin
      if (op_active) begin
        if (exp_ready) begin
          held_q = pend_q;
          held_r = pend_r;
          held_dz = pend_dz;
        end
        if (div_if.cancel || cyc == ready_cyc) op_active = 1'b0;
      end else if (acc) begin
        refDiv(div_if.signed_div, div_if.dividend, div_if.divisor, mq, mr, mdz, lat);
        pend_q = mq;
        pend_r = mr;
        pend_dz = mdz;
        ready_cyc = cyc + lat;
        op_active = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input logic sg, input logic [31:0] a, input logic [31:0] b, output int t0);
    div_if.signed_div = sg;
    div_if.dividend   = a;
    div_if.divisor    = b;
    div_if.start      = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    div_if.start = 1'b0;
  endtask

  task automatic awaitResult(input int t0, input logic [31:0] eq, input logic [31:0] er,
                             input logic edz, input int elat, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (div_if.ready) begin
        seen = 1'b1;
        checkOutput({tag, "_lat"}, 32'(cyc - t0), 32'(elat));
        checkOutput({tag, "_q"}, div_if.quotient, eq);
        checkOutput({tag, "_r"}, div_if.remainder, er);
        checkOutput({tag, "_dz"}, 32'(div_if.div_by_zero), 32'(edz));
      end
    end
    checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic runOp(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz,
                       input int elat, input string tag);
    int t0;
    applyStimulus(sg, a, b, t0);
    awaitResult(t0, eq, er, edz, elat, tag);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 20));
      4: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int t0;
    int ready_cnt;
    div_if.start = 1'b0;
    div_if.signed_div = 1'b0;
    div_if.cancel = 1'b0;
    div_if.dividend = '0;
    div_if.divisor = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;

    runOp(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, "u100_7");
    runOp(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, "s_m7_2");
    runOp(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, "s7_m2");
    runOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33, "min_m1");
    runOp(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 33, "u5_0");

    // Cancel during CALC: no ready, previous results (5/0) stay visible.
    applyStimulus(1'b0, 32'd1234, 32'd5, t0);
    repeat (9) @(posedge clk);
    #1 div_if.cancel = 1'b1;
    @(posedge clk); #1;
    div_if.cancel = 1'b0;
    @(negedge clk);
    checkOutput("cancel_busy", 32'(div_if.busy), 32'd0);
    checkOutput("cancel_q", div_if.quotient, 32'hFFFF_FFFF);
    checkOutput("cancel_r", div_if.remainder, 32'd5);
    checkOutput("cancel_dz", 32'(div_if.div_by_zero), 32'd1);
    ready_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (div_if.ready) ready_cnt++;
    end
    checkOutput("cancel_noready", 32'(ready_cnt), 32'd0);
    @(posedge clk); #1;

    // A second start while busy must be ignored.
    applyStimulus(1'b0, 32'd50, 32'd6, t0);
    repeat (4) @(posedge clk);
    #1;
    div_if.start = 1'b1;
    div_if.signed_div = 1'b1;
    div_if.dividend = 32'd99;
    div_if.divisor = 32'd4;
    @(posedge clk); #1;
    div_if.start = 1'b0;
    awaitResult(t0, 32'd8, 32'd2, 1'b0, 33, "dbl_start");

    // Asynchronous reset in the middle of CALC, away from any clock edge.
    applyStimulus(1'b0, 32'd1000, 32'd3, t0);
    repeat (14) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(div_if.busy), 32'd0);
    checkOutput("rst_stall", 32'(div_if.stallreq), 32'd0);
    checkOutput("rst_ready", 32'(div_if.ready), 32'd0);
    checkOutput("rst_q", div_if.quotient, 32'd0);
    checkOutput("rst_r", div_if.remainder, 32'd0);
    checkOutput("rst_dz", 32'(div_if.div_by_zero), 32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    runOp(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, "u9_3");
    runOp(1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, EARLY_LAT, "u3_10");

    // Random traffic: operands change every cycle, stray starts and occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      div_if.start = ($urandom_range(0, 3) == 0);
      div_if.cancel = ($urandom_range(0, 99) == 0);
      div_if.signed_div = 1'($urandom_range(0, 1));
      div_if.dividend = pickOperand();
      div_if.divisor = pickOperand();
      @(posedge clk); #1;
    end
    div_if.start = 1'b0;
    div_if.cancel = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("drain_busy", 32'(div_if.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
